// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
//   Round-robin arbitration at frame granularity: a grant is held until the
//   requester's req_last byte has been serialized, or until the locked
//   requester stalls for FRAME_TIMEOUT cycles mid-frame (frame_abort pulse).
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, each granted frame is preceded by a tag byte
//   {TAG_BASE[7:4], grant_id} on the serial line. The TAG_BASE parameter
//   exists only in that build.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   req_valid    per-requester byte valid
//   req_data     byte i at [8*i+7:8*i]
//   req_last     byte is the final byte of its frame
//   req_ready    combinational accept, only for the granted requester in LOAD
//   tx_data      registered byte to uart_tx data_in
//   tx_send      registered one-cycle pulse to uart_tx send_trigger
//   tx_ready     uart_tx ready
//   grant_id     current/last granted requester
//   grant_valid  high while a frame is locked
//   frame_abort  one-cycle pulse on timeout release
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned FRAME_TIMEOUT = 1024
`ifdef UART_ARB_TAG_EN
    ,
    parameter logic [7:0]  TAG_BASE      = 8'hA0
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid,
    output logic                       frame_abort
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TOW = $clog2(FRAME_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef UART_ARB_TAG_EN
        ST_TAG,
`endif
        ST_LOAD,
        ST_WAIT_LOW,
        ST_WAIT_HIGH
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] grant_id_n;
    logic           grant_valid_n;
    logic [7:0]     tx_data_n;
    logic           tx_send_n;
    logic           frame_abort_n;
    logic           last_q, last_n;
    logic [TOW-1:0] to_cnt, to_n;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    int unsigned    scan_idx;
    logic [IDW-1:0] next_ptr;

    // First requesting index at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = 32'(ptr) + i;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            cand = IDW'(scan_idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // After a frame the granted requester drops to lowest priority.
    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            frame_abort <= 1'b0;
            last_q      <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant_id    <= grant_id_n;
            grant_valid <= grant_valid_n;
            tx_data     <= tx_data_n;
            tx_send     <= tx_send_n;
            frame_abort <= frame_abort_n;
            last_q      <= last_n;
            to_cnt      <= to_n;
        end
    end

    // Next-state and next register values
    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;
        tx_data_n     = tx_data;
        tx_send_n     = 1'b0;
        frame_abort_n = 1'b0;
        last_n        = last_q;
        to_n          = to_cnt;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_id_n    = winner;
                    grant_valid_n = 1'b1;
                    to_n          = '0;
`ifdef UART_ARB_TAG_EN
                    state_n       = ST_TAG;
`else
                    state_n       = ST_LOAD;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_data_n = {TAG_BASE[7:4], 4'(grant_id)};
                tx_send_n = 1'b1;
                last_n    = 1'b0;
                state_n   = ST_WAIT_LOW;
            end
`endif
            ST_LOAD: begin
                if (req_valid[grant_id]) begin
                    tx_data_n = req_data[{grant_id, 3'b000} +: 8];
                    tx_send_n = 1'b1;
                    last_n    = req_last[grant_id];
                    to_n      = '0;
                    state_n   = ST_WAIT_LOW;
                end else if (to_cnt == TOW'(FRAME_TIMEOUT - 1)) begin
                    // FRAME_TIMEOUT consecutive stalled LOAD cycles
                    frame_abort_n = 1'b1;
                    grant_valid_n = 1'b0;
                    ptr_n         = next_ptr;
                    to_n          = '0;
                    state_n       = ST_IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!tx_ready) state_n = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_valid_n = 1'b0;
                        ptr_n         = next_ptr;
                        state_n       = ST_IDLE;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs: only the granted requester sees ready, and only in LOAD
    always_comb begin
        req_ready = '0;
        if (state == ST_LOAD) req_ready[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NUM_REQ=4, FRAME_TIMEOUT=16)
//   with a behavioural serializer that holds ready low for BIT_CYC cycles
//   after each send. Expected {grant_id, byte} pairs are queued in the order
//   the arbitration rules dictate and compared on every tx_send pulse.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int FT      = 16;
    localparam int BIT_CYC = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [7:0]      tx_data;
    logic            tx_send;
    logic            model_ready = 1'b1;
    logic [1:0]      grant_id;
    logic            grant_valid;
    logic            frame_abort;

    int              n_chk = 0;
    int              n_fail = 0;
    logic [8:0]      feed_q [NREQ][$];
    logic [9:0]      exp_q [$];
    int              busy_cnt = 0;
    int              load_run = 0;
    int              n_abort = 0;
    logic            prev_send = 1'b0;
    logic            r3_leak = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .FRAME_TIMEOUT(FT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_ready    (model_ready),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic feed(input int id, input logic [7:0] data, input logic last);
        feed_q[id].push_back({last, data});
    endtask

    task automatic expect_byte(input int id, input logic [7:0] data);
        logic [1:0] gid;
        gid = 2'(id);
        exp_q.push_back({gid, data});
    endtask

    task automatic expect_tag(input int id);
`ifdef UART_ARB_TAG_EN
        logic [1:0] gid;
        gid = 2'(id);
        exp_q.push_back({gid, 4'hA, 2'b00, gid});
`else
        if (id < 0) $display("bad requester id %0d", id);
`endif
    endtask

    function automatic bit feeds_empty();
        for (int i = 0; i < NREQ; i++)
            if (feed_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && feeds_empty() && !grant_valid && model_ready)
                done = 1'b1;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) feed_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Requester drivers: accept on valid & ready sampled mid-cycle, then
    // present the next queued byte after the edge.
    initial begin
        logic [3:0] hs;
        logic [8:0] ent;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready & {4{!reset}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && feed_q[i].size() > 0) void'(feed_q[i].pop_front());
                if (feed_q[i].size() > 0) begin
                    ent              = feed_q[i][0];
                    req_valid[i]     = 1'b1;
                    req_data[8*i+:8] = ent[7:0];
                    req_last[i]      = ent[8];
                end else begin
                    req_valid[i]     = 1'b0;
                    req_data[8*i+:8] = 8'h00;
                    req_last[i]      = 1'b0;
                end
            end
        end
    end

    // Serializer model and output monitor
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_ready = 1'b1;
                busy_cnt    = 0;
                prev_send   = 1'b0;
                load_run    = 0;
            end else begin
                if (tx_send) begin
                    check("send_gated", model_ready, 1'b1);
                    check("send_single", prev_send, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", {grant_id, tx_data}, e);
                    end
                    model_ready = 1'b0;
                    busy_cnt    = BIT_CYC;
                end else if (!model_ready) begin
                    busy_cnt--;
                    if (busy_cnt == 0) model_ready = 1'b1;
                end
                if (frame_abort) begin
                    check("abort_gv", grant_valid, 1'b0);
                    check("abort_delay", load_run, FT);
                    n_abort++;
                end
                if (grant_valid && grant_id == 2'd1 && req_ready[3]) r3_leak = 1'b1;
                load_run  = (req_ready != 0) ? load_run + 1 : 0;
                prev_send = tx_send;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_send", tx_send, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_frame_abort", frame_abort, 1'b0);
        check("rst_req_ready", req_ready, 4'h0);

        // Single frame from req0, with first-byte latency
        feed(0, 8'h55, 1'b0);
        feed(0, 8'hAA, 1'b1);
        expect_tag(0);
        expect_byte(0, 8'h55);
        expect_byte(0, 8'hAA);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (tx_send) lat = c;
        end
        check("first_latency", lat, 3);
        check("frame_gv", grant_valid, 1'b1);
        check("frame_gid", grant_id, 2'd0);
        wait_idle("single_frame_done", 2000);
        check("gid_hold", grant_id, 2'd0);

        // Pointer now 1: req1 beats req0
        feed(0, 8'hE0, 1'b1);
        feed(1, 8'hE1, 1'b1);
        expect_tag(1);
        expect_byte(1, 8'hE1);
        expect_tag(0);
        expect_byte(0, 8'hE0);
        wait_idle("ptr_after_frame_done", 2000);

        // Contention from reset; req0 re-requests while req2 waits
        do_reset();
        feed(0, 8'h11, 1'b1);
        feed(0, 8'h33, 1'b1);
        feed(2, 8'h22, 1'b1);
        expect_tag(0);
        expect_byte(0, 8'h11);
        expect_tag(2);
        expect_byte(2, 8'h22);
        expect_tag(0);
        expect_byte(0, 8'h33);
        wait_idle("contention_done", 4000);

        // Lock hold: pointer is 1, req1 3-byte frame, req3 pending throughout
        feed(1, 8'h01, 1'b0);
        feed(1, 8'h02, 1'b0);
        feed(1, 8'h03, 1'b1);
        feed(3, 8'hF3, 1'b1);
        expect_tag(1);
        expect_byte(1, 8'h01);
        expect_byte(1, 8'h02);
        expect_byte(1, 8'h03);
        expect_tag(3);
        expect_byte(3, 8'hF3);
        wait_idle("lock_done", 4000);
        check("lock_ready3_leak", r3_leak, 1'b0);

        // Timeout: pointer wrapped to 0, req0 stalls after a non-last byte
        feed(0, 8'h77, 1'b0);
        feed(2, 8'h99, 1'b1);
        expect_tag(0);
        expect_byte(0, 8'h77);
        expect_tag(2);
        expect_byte(2, 8'h99);
        wait_idle("timeout_done", 4000);
        check("abort_count", n_abort, 1);
        check("after_abort_gid", grant_id, 2'd2);

        // Reset while the serializer is busy with a byte from req2
        feed(2, 8'h5A, 1'b0);
        feed(2, 8'h5B, 1'b1);
        expect_tag(2);
        expect_byte(2, 8'h5A);
        lat = 0;
        for (int c = 0; c < 2000 && lat == 0; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) lat = 1;
        end
        check("mid_byte_reached", lat, 1);
        repeat (3) @(negedge clk);
        check("mid_byte_locked", grant_valid, 1'b1);
        do_reset();
        @(negedge clk);
        check("mrst_tx_data", tx_data, 8'h00);
        check("mrst_tx_send", tx_send, 1'b0);
        check("mrst_grant_id", grant_id, 2'd0);
        check("mrst_grant_valid", grant_valid, 1'b0);
        check("mrst_frame_abort", frame_abort, 1'b0);
        check("mrst_req_ready", req_ready, 4'h0);
        check("mrst_line_idle", model_ready, 1'b1);
        feed(2, 8'hC2, 1'b1);
        expect_tag(2);
        expect_byte(2, 8'hC2);
        wait_idle("post_reset_frame_done", 2000);
        check("post_reset_gid", grant_id, 2'd2);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
